kmap_lut_sweeper: RTL and testbench

//   Parametrised, programmable N-input boolean function unit. The truth table is

---
 rtl/kmap_pkg.sv | 10 +
 rtl/kmap_tt_ram.sv | 36 +++
 rtl/kmap_lut_sweeper.sv | 114 +++++++++++
 tb/tb_kmap_lut_sweeper.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kmap_pkg.sv
// Shared encodings for the K-map function unit: sweep FSM states.
package kmap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : kmap_pkg

// File: rtl/kmap_tt_ram.sv
// Truth-table storage: 2**N_IN x 1 register array, one synchronous write port,
// two combinational read ports (single evaluation and sweep).
module kmap_tt_ram #(
    parameter int N_IN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_we,
    input  logic [N_IN-1:0] i_waddr,
    input  logic            i_wdata,
    input  logic [N_IN-1:0] i_raddr_a,
    output logic            o_rdata_a,
    input  logic [N_IN-1:0] i_raddr_b,
    output logic            o_rdata_b
);

    localparam int DEPTH = 1 << N_IN;

    logic [DEPTH-1:0] r_mem;

    // NOTE: the table is reset on purpose -- a cleared function is part of the
    // unit's reset state, so the array cannot be left as uninitialised storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // NOTE: reads are combinational off the array, so a register capturing a
    // read in the same cycle as a write to that entry sees the old contents.
    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule : kmap_tt_ram

// File: rtl/kmap_lut_sweeper.sv
// Programmable N-input boolean function: per-minterm loading, registered single
// evaluation, and an autonomous sweep that streams f() and counts set minterms.
module kmap_lut_sweeper
    import kmap_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int CNT_W = N_IN + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [N_IN-1:0]  cfg_addr,
    input  logic             cfg_data,
    input  logic [N_IN-1:0]  eval_in,
    output logic             eval_y,
    input  logic             start,
    output logic             busy,
    output logic             sweep_valid,
    output logic [N_IN-1:0]  sweep_vec,
    output logic             sweep_y,
    output logic             done,
    output logic [CNT_W-1:0] ones_cnt
);

    state_t             r_state;
    logic [N_IN-1:0]    r_idx;
    logic               r_busy;
    logic               r_sweep_valid;
    logic [N_IN-1:0]    r_sweep_vec;
    logic               r_sweep_y;
    logic               r_done;
    logic               r_eval_y;
    logic [CNT_W-1:0]   r_ones_cnt;

    logic               w_tt_we;
    logic               w_eval_bit;
    logic               w_sweep_bit;

    // The table is frozen for the whole time busy is high, including the done cycle.
    assign w_tt_we = cfg_we & ~r_busy;

    kmap_tt_ram #(
        .N_IN (N_IN)
    ) u_tt_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_tt_we),
        .i_waddr   (cfg_addr),
        .i_wdata   (cfg_data),
        .i_raddr_a (eval_in),
        .o_rdata_a (w_eval_bit),
        .i_raddr_b (r_idx),
        .o_rdata_b (w_sweep_bit)
    );

    // NOTE: all state and output registers use non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_busy        <= 1'b0;
            r_sweep_valid <= 1'b0;
            r_sweep_vec   <= '0;
            r_sweep_y     <= 1'b0;
            r_done        <= 1'b0;
            r_eval_y      <= 1'b0;
            r_ones_cnt    <= '0;
        end else begin
            r_eval_y <= w_eval_bit;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    if (start) begin
                        r_state    <= ST_SWEEP;
                        r_idx      <= '0;
                        r_ones_cnt <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    r_sweep_valid <= 1'b1;
                    r_sweep_vec   <= r_idx;
                    r_sweep_y     <= w_sweep_bit;
                    r_ones_cnt    <= r_ones_cnt + CNT_W'(w_sweep_bit);
                    // Stop on the last vector rather than wrapping the index.
                    if (r_idx == '1) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done        <= 1'b1;
                    r_sweep_valid <= 1'b0;
                    r_state       <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign eval_y      = r_eval_y;
    assign busy        = r_busy;
    assign sweep_valid = r_sweep_valid;
    assign sweep_vec   = r_sweep_vec;
    assign sweep_y     = r_sweep_y;
    assign done        = r_done;
    assign ones_cnt    = r_ones_cnt;

endmodule : kmap_lut_sweeper

// File: tb/tb_kmap_lut_sweeper.sv
// Directed bench for kmap_lut_sweeper: a 4-input and a 3-input instance share
// clock and reset; every expectation is a hand-computed constant.
module tb_kmap_lut_sweeper;

    logic       clk;
    logic       rst_n;

    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic       cfg_data;
    logic [3:0] eval_in;
    logic       eval_y;
    logic       start;
    logic       busy;
    logic       sweep_valid;
    logic [3:0] sweep_vec;
    logic       sweep_y;
    logic       done;
    logic [4:0] ones_cnt;

    logic       cfg_we_3;
    logic [2:0] cfg_addr_3;
    logic       cfg_data_3;
    logic [2:0] eval_in_3;
    logic       eval_y_3;
    logic       start_3;
    logic       busy_3;
    logic       sweep_valid_3;
    logic [2:0] sweep_vec_3;
    logic       sweep_y_3;
    logic       done_3;
    logic [3:0] ones_cnt_3;

    int errors;
    int checks;

    kmap_lut_sweeper #(.N_IN(4)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .eval_in     (eval_in),
        .eval_y      (eval_y),
        .start       (start),
        .busy        (busy),
        .sweep_valid (sweep_valid),
        .sweep_vec   (sweep_vec),
        .sweep_y     (sweep_y),
        .done        (done),
        .ones_cnt    (ones_cnt)
    );

    kmap_lut_sweeper #(.N_IN(3)) u_dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we_3),
        .cfg_addr    (cfg_addr_3),
        .cfg_data    (cfg_data_3),
        .eval_in     (eval_in_3),
        .eval_y      (eval_y_3),
        .start       (start_3),
        .busy        (busy_3),
        .sweep_valid (sweep_valid_3),
        .sweep_vec   (sweep_vec_3),
        .sweep_y     (sweep_y_3),
        .done        (done_3),
        .ones_cnt    (ones_cnt_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic write_tt(input logic [3:0] addr, input logic data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic check_eval_all(input logic [15:0] exp_tt, input string name);
        for (int a = 0; a < 16; a++) begin
            eval_in = 4'(a);
            @(negedge clk);
            checks++;
            if (eval_y !== exp_tt[a]) begin
                errors++;
                $display("FAIL %s eval_in=%0d: eval_y=%b expected %b", name, a, eval_y, exp_tt[a]);
            end
        end
    endtask

    // Runs one sweep on the 4-input DUT; k counts edges after the start edge.
    task automatic run_sweep(input logic [15:0] exp_tt, input int exp_ones,
                             input bit poke_cfg, input bit poke_start, input string name);
        int n_valid;
        logic [3:0] exp_vec;
        n_valid = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            cfg_we = 1'b0;
            start  = 1'b0;
            if (poke_cfg && k == 3) begin
                cfg_we   = 1'b1;
                cfg_addr = 4'd3;
                cfg_data = 1'b1;
            end
            if (poke_start && k == 5) start = 1'b1;
            @(negedge clk);
            if (sweep_valid === 1'b1) n_valid++;
            checks++;
            if (sweep_valid !== (k >= 1 && k <= 16)) begin
                errors++;
                $display("FAIL %s valid k=%0d: sweep_valid=%b expected %b", name, k, sweep_valid, (k <= 16));
            end
            if (k <= 16) begin
                exp_vec = 4'(k - 1);
                checks++;
                if (sweep_vec !== exp_vec || sweep_y !== exp_tt[k-1]) begin
                    errors++;
                    $display("FAIL %s vec k=%0d: vec=%0d y=%b expected vec=%0d y=%b",
                             name, k, sweep_vec, sweep_y, exp_vec, exp_tt[k-1]);
                end
            end
            checks++;
            if (done !== (k == 17)) begin
                errors++;
                $display("FAIL %s done k=%0d: done=%b expected %b", name, k, done, (k == 17));
            end
            if (k >= 16) begin
                checks++;
                if (busy !== (k <= 17)) begin
                    errors++;
                    $display("FAIL %s busy k=%0d: busy=%b expected %b", name, k, busy, (k <= 17));
                end
                checks++;
                if (ones_cnt !== 5'(exp_ones)) begin
                    errors++;
                    $display("FAIL %s ones_cnt k=%0d: got %0d expected %0d", name, k, ones_cnt, exp_ones);
                end
            end
        end
        cfg_we = 1'b0;
        start  = 1'b0;
        checks++;
        if (n_valid != 16) begin
            errors++;
            $display("FAIL %s valid_count: got %0d expected 16", name, n_valid);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (busy !== 1'b0 || sweep_valid !== 1'b0 || done !== 1'b0 ||
            ones_cnt !== 5'd0 || sweep_vec !== 4'd0 || sweep_y !== 1'b0 || eval_y !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b valid=%b done=%b cnt=%0d vec=%0d y=%b eval_y=%b expected all 0",
                     busy, sweep_valid, done, ones_cnt, sweep_vec, sweep_y, eval_y);
        end
        check_eval_all(16'h0000, "reset_eval");
    endtask

    task automatic test_sweep_pattern();
        logic [15:0] tt;
        tt = 16'h0147;
        for (int a = 0; a < 16; a++) write_tt(4'(a), tt[a]);
        check_eval_all(tt, "pattern_eval");
        run_sweep(tt, 5, 1'b0, 1'b0, "pattern_sweep");
    endtask

    task automatic test_full_and_empty();
        for (int a = 0; a < 16; a++) write_tt(4'(a), 1'b1);
        run_sweep(16'hFFFF, 16, 1'b0, 1'b0, "all_ones");
        for (int a = 0; a < 16; a++) write_tt(4'(a), 1'b0);
        run_sweep(16'h0000, 0, 1'b0, 1'b0, "all_zeros");
    endtask

    task automatic test_frozen_during_sweep();
        logic [15:0] tt;
        tt = 16'h0147;
        for (int a = 0; a < 16; a++) write_tt(4'(a), tt[a]);
        run_sweep(tt, 5, 1'b1, 1'b1, "busy_ignore");
        check_eval_all(tt, "frozen_eval");
    endtask

    task automatic test_reset_mid_sweep();
        bit found;
        found = 1'b0;
        for (int a = 0; a < 16; a++) write_tt(4'(a), 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (sweep_valid === 1'b1 && sweep_vec === 4'd7) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midreset_wait: vec 7 not seen within 30 cycles");
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || sweep_valid !== 1'b0 || ones_cnt !== 5'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: busy=%b valid=%b cnt=%0d done=%b expected 0 0 0 0",
                     busy, sweep_valid, ones_cnt, done);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || sweep_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_quiet k=%0d: done=%b valid=%b expected 0 0", k, done, sweep_valid);
            end
        end
        check_eval_all(16'h0000, "midreset_eval");
    endtask

    task automatic test_read_before_write();
        eval_in  = 4'd5;
        cfg_we   = 1'b1;
        cfg_addr = 4'd5;
        cfg_data = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        checks++;
        if (eval_y !== 1'b0) begin
            errors++;
            $display("FAIL rbw_old: eval_y=%b expected 0", eval_y);
        end
        @(negedge clk);
        checks++;
        if (eval_y !== 1'b1) begin
            errors++;
            $display("FAIL rbw_new: eval_y=%b expected 1", eval_y);
        end
    endtask

    task automatic test_n_in_3();
        logic [7:0] tt;
        int n_valid;
        logic [2:0] exp_vec;
        tt = 8'h92;
        n_valid = 0;
        for (int a = 0; a < 8; a++) begin
            cfg_we_3   = 1'b1;
            cfg_addr_3 = 3'(a);
            cfg_data_3 = tt[a];
            @(negedge clk);
        end
        cfg_we_3 = 1'b0;
        start_3 = 1'b1;
        @(negedge clk);
        start_3 = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (sweep_valid_3 === 1'b1) n_valid++;
            checks++;
            if (sweep_valid_3 !== (k <= 8)) begin
                errors++;
                $display("FAIL n3_valid k=%0d: sweep_valid=%b expected %b", k, sweep_valid_3, (k <= 8));
            end
            if (k <= 8) begin
                exp_vec = 3'(k - 1);
                checks++;
                if (sweep_vec_3 !== exp_vec || sweep_y_3 !== tt[k-1]) begin
                    errors++;
                    $display("FAIL n3_vec k=%0d: vec=%0d y=%b expected vec=%0d y=%b",
                             k, sweep_vec_3, sweep_y_3, exp_vec, tt[k-1]);
                end
            end
            checks++;
            if (done_3 !== (k == 9)) begin
                errors++;
                $display("FAIL n3_done k=%0d: done=%b expected %b", k, done_3, (k == 9));
            end
        end
        checks++;
        if (n_valid != 8 || ones_cnt_3 !== 4'd3 || busy_3 !== 1'b0) begin
            errors++;
            $display("FAIL n3_summary: valid=%0d cnt=%0d busy=%b expected 8 3 0", n_valid, ones_cnt_3, busy_3);
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rst_n      = 1'b1;
        cfg_we     = 1'b0;
        cfg_addr   = 4'd0;
        cfg_data   = 1'b0;
        eval_in    = 4'd0;
        start      = 1'b0;
        cfg_we_3   = 1'b0;
        cfg_addr_3 = 3'd0;
        cfg_data_3 = 1'b0;
        eval_in_3  = 3'd0;
        start_3    = 1'b0;

        test_reset();
        test_sweep_pattern();
        test_full_and_empty();
        test_frozen_during_sweep();
        test_reset_mid_sweep();
        test_read_before_write();
        test_n_in_3();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_kmap_lut_sweeper
